// File: rtl/pio_regs_mc.sv
// Multi-bank GPIO register block: per-bank DIR/OUT/IN/IRQ registers behind a
// two-state bus access FSM, with synchronised inputs and edge-triggered interrupts.
module pio_regs_mc #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BANKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sel,
  input  logic                            RW,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            busy,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] pio_in,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] pio_out,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] pio_oe,
  output logic                            irq
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    irq_q, irq_d;

  logic [DATA_WIDTH-1:0]   dir_q  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   dir_d  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   out_q  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   out_d  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   en_q   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   en_d   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   stat_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   stat_d [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   pol_q  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   pol_d  [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   sync_q [NUM_BANKS][SYNC_STAGES];
  logic [DATA_WIDTH-1:0]   sync_d [NUM_BANKS][SYNC_STAGES];
  logic [DATA_WIDTH-1:0]   hist_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   hist_d [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   evt    [NUM_BANKS];

  logic [31:0]             bank_ext;
  logic [2:0]              reg_sel;
  logic                    do_wr;
  logic                    do_rd;

  assign bank_ext = 32'(addr_q[ADDR_WIDTH-1:3]);
  assign reg_sel  = addr_q[2:0];
  assign do_wr    = (state_q == ACCESS) && rw_q;
  assign do_rd    = (state_q == ACCESS) && !rw_q;

  assign busy  = (state_q == ACCESS);
  assign rdata = rdata_q;
  assign irq   = irq_q;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign evt[g] = (pol_q[g] & ~sync_q[g][SYNC_STAGES-1] & hist_q[g])
                  | (~pol_q[g] & sync_q[g][SYNC_STAGES-1] & ~hist_q[g]);
    assign pio_out[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
    assign pio_oe[g*DATA_WIDTH +: DATA_WIDTH]  = dir_q[g];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    irq_d   = 1'b0;
    dir_d   = dir_q;
    out_d   = out_q;
    en_d    = en_q;
    stat_d  = stat_q;
    pol_d   = pol_q;
    sync_d  = sync_q;
    hist_d  = hist_q;

    case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d  = addr;
          rw_d    = RW;
          wdata_d = wdata;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Out-of-range banks match no loop iteration, so reads fall back to zero.
    if (do_rd) rdata_d = '0;

    for (int b = 0; b < NUM_BANKS; b++) begin
      sync_d[b][0] = pio_in[b*DATA_WIDTH +: DATA_WIDTH];
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[b][s] = sync_q[b][s-1];
      hist_d[b] = sync_q[b][SYNC_STAGES-1];
      stat_d[b] = stat_q[b] | evt[b];
      irq_d     = irq_d | (|(stat_q[b] & en_q[b]));

      if (do_wr && (bank_ext == 32'(b))) begin
        case (reg_sel)
          3'd0:    dir_d[b]  = wdata_q;
          3'd1:    out_d[b]  = wdata_q;
          3'd3:    en_d[b]   = wdata_q;
          3'd4:    stat_d[b] = (stat_q[b] & ~wdata_q) | evt[b];
          3'd5:    out_d[b]  = out_q[b] | wdata_q;
          3'd6:    out_d[b]  = out_q[b] & ~wdata_q;
          3'd7:    pol_d[b]  = wdata_q;
          default: ;
        endcase
      end

      if (do_rd && (bank_ext == 32'(b))) begin
        case (reg_sel)
          3'd0:    rdata_d = dir_q[b];
          3'd1:    rdata_d = out_q[b];
          3'd2:    rdata_d = sync_q[b][SYNC_STAGES-1];
          3'd3:    rdata_d = en_q[b];
          3'd4:    rdata_d = stat_q[b];
          3'd7:    rdata_d = pol_q[b];
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        dir_q[b]  <= '0;
        out_q[b]  <= '0;
        en_q[b]   <= '0;
        stat_q[b] <= '0;
        pol_q[b]  <= '0;
        hist_q[b] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[b][s] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      pol_q   <= pol_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
    end
  end

endmodule

// File: tb/tb_pio_regs_mc.sv
// Directed self-checking bench for pio_regs_mc: bus timing, register map,
// set/clear, edge interrupts, busy-ignore, out-of-range banks and reset abort.
module tb_pio_regs_mc;

  logic         clk;
  logic         reset;
  logic         sel;
  logic         RW;
  logic [7:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         busy;
  logic [127:0] pio_in;
  logic [127:0] pio_out;
  logic [127:0] pio_oe;
  logic         irq;

  int n_compared;
  int n_mismatched;
  logic [31:0] rd_val;

  pio_regs_mc dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .RW      (RW),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .pio_in  (pio_in),
    .pio_out (pio_out),
    .pio_oe  (pio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access; ends at the negedge after completion, with rd returning rdata.
  task automatic applyStimulus(input logic rw, input logic [7:0] a, input logic [31:0] d,
                               output logic [31:0] rd);
    @(negedge clk);
    sel = 1'b1; RW = rw; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0;
    checkOutput($sformatf("busy_hi_%02h", a), {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput($sformatf("busy_lo_%02h", a), {31'd0, busy}, 32'd0);
    rd = rdata;
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0;
    reset = 1'b1; sel = 1'b0; RW = 1'b0; addr = '0; wdata = '0; pio_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_out1", pio_out[63:32], 32'd0);
    checkOutput("rst_oe3", pio_oe[127:96], 32'd0);

    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 8; r++) begin
        applyStimulus(1'b0, 8'(b * 8 + r), 32'd0, rd_val);
        checkOutput($sformatf("rst_read_b%0d_r%0d", b, r), rd_val, 32'd0);
      end
    end
    checkOutput("rst_irq_after_reads", {31'd0, irq}, 32'd0);

    applyStimulus(1'b1, 8'h08, 32'hFFFF0000, rd_val);
    checkOutput("oe_bank1", pio_oe[63:32], 32'hFFFF0000);
    applyStimulus(1'b1, 8'h09, 32'h12345678, rd_val);
    checkOutput("out_bank1", pio_out[63:32], 32'h12345678);
    checkOutput("oe_bank0_untouched", pio_oe[31:0], 32'd0);
    applyStimulus(1'b0, 8'h08, 32'd0, rd_val);
    checkOutput("rd_dir_bank1", rd_val, 32'hFFFF0000);
    applyStimulus(1'b0, 8'h09, 32'd0, rd_val);
    checkOutput("rd_out_bank1", rd_val, 32'h12345678);

    applyStimulus(1'b1, 8'h01, 32'h0000000F, rd_val);
    applyStimulus(1'b1, 8'h05, 32'h000000F0, rd_val);
    checkOutput("out_set", pio_out[31:0], 32'h000000FF);
    applyStimulus(1'b1, 8'h06, 32'h00000003, rd_val);
    checkOutput("out_clr", pio_out[31:0], 32'h000000FC);
    applyStimulus(1'b0, 8'h01, 32'd0, rd_val);
    checkOutput("rd_out_bank0", rd_val, 32'h000000FC);
    applyStimulus(1'b0, 8'h05, 32'd0, rd_val);
    checkOutput("rd_out_set_zero", rd_val, 32'd0);
    applyStimulus(1'b0, 8'h06, 32'd0, rd_val);
    checkOutput("rd_out_clr_zero", rd_val, 32'd0);

    // Rising edge on bank2 bit0: STAT at the 3rd edge, irq at the 4th.
    applyStimulus(1'b1, 8'h13, 32'h1, rd_val);
    applyStimulus(1'b1, 8'h17, 32'h0, rd_val);
    @(negedge clk);
    pio_in[64] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("irq_rise_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_rise", {31'd0, irq}, 32'd1);
    applyStimulus(1'b0, 8'h14, 32'd0, rd_val);
    checkOutput("stat_rise", rd_val, 32'h1);
    applyStimulus(1'b0, 8'h12, 32'd0, rd_val);
    checkOutput("in_high", rd_val, 32'h1);
    applyStimulus(1'b1, 8'h14, 32'h1, rd_val);
    checkOutput("irq_still_high_after_w1c", {31'd0, irq}, 32'd1);
    @(negedge clk);
    checkOutput("irq_low_after_w1c", {31'd0, irq}, 32'd0);

    // Falling edge with POL=1.
    applyStimulus(1'b1, 8'h17, 32'h1, rd_val);
    applyStimulus(1'b0, 8'h17, 32'd0, rd_val);
    checkOutput("rd_pol", rd_val, 32'h1);
    @(negedge clk);
    pio_in[64] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("irq_fall_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_fall", {31'd0, irq}, 32'd1);
    applyStimulus(1'b0, 8'h14, 32'd0, rd_val);
    checkOutput("stat_fall", rd_val, 32'h1);
    applyStimulus(1'b0, 8'h12, 32'd0, rd_val);
    checkOutput("in_low", rd_val, 32'h0);
    applyStimulus(1'b1, 8'h14, 32'h1, rd_val);
    @(negedge clk);
    checkOutput("irq_low_after_w1c2", {31'd0, irq}, 32'd0);

    // Rising edge lands on the same edge as a W1C of that bit: the set wins.
    applyStimulus(1'b1, 8'h17, 32'h0, rd_val);
    pio_in[64] = 1'b1;
    applyStimulus(1'b1, 8'h14, 32'h1, rd_val);
    applyStimulus(1'b0, 8'h14, 32'd0, rd_val);
    checkOutput("stat_set_beats_clear", rd_val, 32'h1);
    checkOutput("irq_after_collision", {31'd0, irq}, 32'd1);
    applyStimulus(1'b1, 8'h14, 32'h1, rd_val);
    @(negedge clk);
    checkOutput("irq_cleared_again", {31'd0, irq}, 32'd0);

    // sel held during ACCESS with a different target must be ignored.
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = 8'h00; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checkOutput("busy_during_hold", {31'd0, busy}, 32'd1);
    addr = 8'h03; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    sel = 1'b0;
    checkOutput("busy_after_hold", {31'd0, busy}, 32'd0);
    checkOutput("oe_bank0_hold", pio_oe[31:0], 32'hA5A5A5A5);
    applyStimulus(1'b0, 8'h03, 32'd0, rd_val);
    checkOutput("en_bank0_unwritten", rd_val, 32'd0);

    // Bank 5 is out of range: no write effect, reads 0, rdata kept across writes.
    applyStimulus(1'b0, 8'h09, 32'd0, rd_val);
    applyStimulus(1'b1, 8'h29, 32'hDEADBEEF, rd_val);
    checkOutput("rdata_kept_on_write", rd_val, 32'h12345678);
    checkOutput("bank5_no_alias_out1", pio_out[63:32], 32'h12345678);
    checkOutput("bank5_no_alias_out0", pio_out[31:0], 32'h000000FC);
    checkOutput("bank5_no_alias_out3", pio_out[127:96], 32'd0);
    applyStimulus(1'b0, 8'h29, 32'd0, rd_val);
    checkOutput("bank5_read_zero", rd_val, 32'd0);

    // Reset asserted during the ACCESS of a write aborts it.
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = 8'h18; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    sel = 1'b0;
    checkOutput("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("busy_after_abort", {31'd0, busy}, 32'd0);
    checkOutput("oe_bank3_after_abort", pio_oe[127:96], 32'd0);
    applyStimulus(1'b0, 8'h18, 32'd0, rd_val);
    checkOutput("dir_bank3_after_abort", rd_val, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
